// File: rtl/ptw_initiator.sv
// Two-level page-table walker: takes a VA from the TLB miss path, reads up to
// two PTEs through a valid/ready memory read port, and returns PA/perm/fault.
// Latency: 4 cycles (superpage) / 6 cycles (4 KB page) from accept with zero-wait memory.
// Backpressure: any handshake that is not ready stalls the FSM with all outputs held.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   walk_req_*  / walk_vaddr_i    walk request from TLB (valid/ready)
//   walk_resp_* / walk_*_o        walk result to TLB (valid/ready)
//   mem_req_*   / mem_addr_o      PTE read request to memory (valid/ready)
//   mem_resp_*  / mem_data_i      PTE read data from memory (valid/ready)
module ptw_initiator #(
  parameter logic [31:0] ROOT_BASE = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        walk_req_valid_i,
  output logic        walk_req_ready_o,
  input  logic [31:0] walk_vaddr_i,
  output logic        walk_resp_valid_o,
  input  logic        walk_resp_ready_i,
  output logic [31:0] walk_paddr_o,
  output logic [3:0]  walk_perm_o,
  output logic        walk_super_o,
  output logic        walk_fault_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_resp_valid_i,
  output logic        mem_resp_ready_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_REQ,
    S_L1_WAIT,
    S_L0_REQ,
    S_L0_WAIT,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [31:0] vaddr_q;
  logic [31:0] mem_addr_q;
  logic        mem_req_valid_q;
  logic        mem_resp_ready_q;
  logic        walk_req_ready_q;
  logic        walk_resp_valid_q;
  logic [31:0] paddr_q;
  logic [3:0]  perm_q;
  logic        super_q;
  logic        fault_q;

  // PTE decode of the word currently presented by memory
  logic pte_v;
  logic pte_leaf;
  logic pte_misalign;
  assign pte_v        = mem_data_i[0];
  assign pte_leaf     = pte_v && (|mem_data_i[3:1]);
  assign pte_misalign = |mem_data_i[21:12];

  // PTE addresses: table base + VPN*4, plain 32-bit wrap-around add
  logic [31:0] l1_addr_d;
  logic [31:0] l0_addr_d;
  assign l1_addr_d = ROOT_BASE + {20'b0, walk_vaddr_i[31:22], 2'b00};
  assign l0_addr_d = {mem_data_i[31:10], 10'b0} + {20'b0, vaddr_q[21:12], 2'b00};

  // PTE bits [9:4] are reserved/software bits and carry no meaning here
  logic unused_pte_bits;
  assign unused_pte_bits = ^mem_data_i[9:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      vaddr_q           <= '0;
      mem_addr_q        <= '0;
      mem_req_valid_q   <= 1'b0;
      mem_resp_ready_q  <= 1'b0;
      walk_req_ready_q  <= 1'b1;
      walk_resp_valid_q <= 1'b0;
      paddr_q           <= '0;
      perm_q            <= '0;
      super_q           <= 1'b0;
      fault_q           <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (walk_req_valid_i) begin
            vaddr_q          <= walk_vaddr_i;
            walk_req_ready_q <= 1'b0;
            mem_addr_q       <= l1_addr_d;
            mem_req_valid_q  <= 1'b1;
            state_q          <= S_L1_REQ;
          end
        end

        S_L1_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q  <= 1'b0;
            mem_resp_ready_q <= 1'b1;
            state_q          <= S_L1_WAIT;
          end
        end

        S_L1_WAIT: begin
          if (mem_resp_valid_i) begin
            mem_resp_ready_q <= 1'b0;
            if (!pte_v) begin
              fault_q           <= 1'b1;
              perm_q            <= '0;
              super_q           <= 1'b0;
              paddr_q           <= '0;
              walk_resp_valid_q <= 1'b1;
              state_q           <= S_DONE;
            end else if (pte_leaf) begin
              // A level-1 leaf maps 4 MB; its low PPN bits must be zero
              fault_q           <= pte_misalign;
              perm_q            <= mem_data_i[3:0];
              super_q           <= 1'b1;
              paddr_q           <= pte_misalign ? 32'h0 : {mem_data_i[31:22], vaddr_q[21:0]};
              walk_resp_valid_q <= 1'b1;
              state_q           <= S_DONE;
            end else begin
              mem_addr_q      <= l0_addr_d;
              mem_req_valid_q <= 1'b1;
              state_q         <= S_L0_REQ;
            end
          end
        end

        S_L0_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q  <= 1'b0;
            mem_resp_ready_q <= 1'b1;
            state_q          <= S_L0_WAIT;
          end
        end

        S_L0_WAIT: begin
          if (mem_resp_valid_i) begin
            mem_resp_ready_q  <= 1'b0;
            walk_resp_valid_q <= 1'b1;
            super_q           <= 1'b0;
            state_q           <= S_DONE;
            if (pte_leaf) begin
              fault_q <= 1'b0;
              perm_q  <= mem_data_i[3:0];
              paddr_q <= {mem_data_i[31:12], vaddr_q[11:0]};
            end else begin
              // Invalid entry, or a pointer where only leaves are legal
              fault_q <= 1'b1;
              perm_q  <= pte_v ? mem_data_i[3:0] : 4'h0;
              paddr_q <= '0;
            end
          end
        end

        S_DONE: begin
          // Ready for a new walk only from the following cycle
          if (walk_resp_ready_i) begin
            walk_resp_valid_q <= 1'b0;
            walk_req_ready_q  <= 1'b1;
            state_q           <= S_IDLE;
          end
        end

        default: begin
          state_q           <= S_IDLE;
          mem_req_valid_q   <= 1'b0;
          mem_resp_ready_q  <= 1'b0;
          walk_resp_valid_q <= 1'b0;
          walk_req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign walk_req_ready_o  = walk_req_ready_q;
  assign walk_resp_valid_o = walk_resp_valid_q;
  assign walk_paddr_o      = paddr_q;
  assign walk_perm_o       = perm_q;
  assign walk_super_o      = super_q;
  assign walk_fault_o      = fault_q;
  assign mem_req_valid_o   = mem_req_valid_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_resp_ready_o  = mem_resp_ready_q;

endmodule

// File: tb/tb_ptw_initiator.sv
module tb_ptw_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        walk_req_valid_i;
  logic        walk_req_ready_o;
  logic [31:0] walk_vaddr_i;
  logic        walk_resp_valid_o;
  logic        walk_resp_ready_i;
  logic [31:0] walk_paddr_o;
  logic [3:0]  walk_perm_o;
  logic        walk_super_o;
  logic        walk_fault_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_resp_valid_i;
  logic        mem_resp_ready_o;
  logic [31:0] mem_data_i;

  ptw_initiator #(.ROOT_BASE(32'h0000_0400)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .walk_req_valid_i  (walk_req_valid_i),
    .walk_req_ready_o  (walk_req_ready_o),
    .walk_vaddr_i      (walk_vaddr_i),
    .walk_resp_valid_o (walk_resp_valid_o),
    .walk_resp_ready_i (walk_resp_ready_i),
    .walk_paddr_o      (walk_paddr_o),
    .walk_perm_o       (walk_perm_o),
    .walk_super_o      (walk_super_o),
    .walk_fault_o      (walk_fault_o),
    .mem_req_valid_o   (mem_req_valid_o),
    .mem_req_ready_i   (mem_req_ready_i),
    .mem_addr_o        (mem_addr_o),
    .mem_resp_valid_i  (mem_resp_valid_i),
    .mem_resp_ready_o  (mem_resp_ready_o),
    .mem_data_i        (mem_data_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] paddr;
    logic [3:0]  perm;
    logic        sup;
    logic        fault;
    int          nrd;
    logic [31:0] a0;
    logic [31:0] a1;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rd_q[$];
  logic [31:0] mem[logic [31:0]];
  int          n_tests = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          stall_cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] pdata = '0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  function automatic exp_t mk(input logic [31:0] pa, input logic [3:0] pm, input logic sp,
                              input logic ft, input int nrd, input logic [31:0] a0,
                              input logic [31:0] a1);
    exp_t e;
    e.paddr = pa; e.perm = pm; e.sup = sp; e.fault = ft; e.nrd = nrd; e.a0 = a0; e.a1 = a1;
    return e;
  endfunction

  // Zero-wait memory: data valid the cycle after the request is accepted.
  // stall_cnt holds off mem_req_ready_i for that many cycles of a pending request.
  initial begin
    mem_req_ready_i  = 1'b1;
    mem_resp_valid_i = 1'b0;
    mem_data_i       = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (mem_resp_valid_i && mem_resp_ready_o) pend = 1'b0;
        if (mem_req_valid_o && mem_req_ready_i) begin
          rd_q.push_back(mem_addr_o);
          pdata = mem_rd(mem_addr_o);
          pend  = 1'b1;
        end else if (mem_req_valid_o && stall_cnt > 0) begin
          stall_cnt--;
        end
      end
      #1;
      mem_resp_valid_i = pend;
      mem_data_i       = pend ? pdata : 32'h0;
      mem_req_ready_i  = (stall_cnt == 0);
    end
  end

  // Result monitor: pop the expected walk and compare on every response handshake
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst_n && walk_resp_valid_o && walk_resp_ready_i) begin
        chk_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk_eq("fault", 32'(walk_fault_o), 32'(e.fault));
          chk_eq("perm", 32'(walk_perm_o), 32'(e.perm));
          if (!e.fault) begin
            chk_eq("paddr", walk_paddr_o, e.paddr);
            chk_eq("super", 32'(walk_super_o), 32'(e.sup));
          end
          chk_eq("num_reads", rd_q.size(), e.nrd);
          if (rd_q.size() > 0) chk_eq("rd_addr0", rd_q[0], e.a0);
          if (rd_q.size() > 1 && e.nrd > 1) chk_eq("rd_addr1", rd_q[1], e.a1);
        end
        rd_q.delete();
        done_cnt++;
      end
    end
  end

  task automatic run_walk(input logic [31:0] va, input exp_t e, input int exp_lat,
                          input int stall, input int hold);
    int n;
    int d0;
    logic [31:0] pa_s;
    logic [3:0]  pm_s;
    logic        ft_s;
    sb.push_back(e);
    d0 = done_cnt;
    @(negedge clk);
    walk_resp_ready_i = (hold == 0);
    stall_cnt         = stall;
    walk_req_valid_i  = 1'b1;
    walk_vaddr_i      = va;
    n = 0;
    while (!walk_req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 walk_req_valid_i = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      chk_eq("req_resp_excl", 32'(mem_req_valid_o & mem_resp_ready_o), 32'd0);
      if (walk_resp_valid_o) break;
      if (mem_req_valid_o && !mem_req_ready_i) chk_eq("req_hold_addr", mem_addr_o, e.a0);
    end
    if (n == 200) chk_eq("resp_timeout", 32'(walk_resp_valid_o), 32'd1);
    else if (exp_lat > 0) chk_eq("latency", n + 2, exp_lat);
    if (hold > 0) begin
      pa_s = walk_paddr_o; pm_s = walk_perm_o; ft_s = walk_fault_o;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk_eq("hold_valid", 32'(walk_resp_valid_o), 32'd1);
        chk_eq("hold_paddr", walk_paddr_o, pa_s);
        chk_eq("hold_perm", 32'(walk_perm_o), 32'(pm_s));
        chk_eq("hold_fault", 32'(walk_fault_o), 32'(ft_s));
      end
      walk_resp_ready_i = 1'b1;
    end
    for (n = 0; n < 20 && done_cnt == d0; n++) @(negedge clk);
    chk_eq("resp_done", done_cnt - d0, 1);
    walk_resp_ready_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    mem[32'h400] = 32'h0000_0801;
    mem[32'h404] = 32'h1234_0007;
    mem[32'h408] = 32'h0000_0000;
    mem[32'h800] = 32'h1000_000F;
    mem[32'h804] = 32'h1100_000F;
    mem[32'h808] = 32'h1200_0007;
    mem[32'h80C] = 32'h0000_0000;

    rst_n             = 1'b1;
    walk_req_valid_i  = 1'b0;
    walk_vaddr_i      = '0;
    walk_resp_ready_i = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_mem_req_valid", 32'(mem_req_valid_o), 32'd0);
    chk_eq("rst_mem_resp_ready", 32'(mem_resp_ready_o), 32'd0);
    chk_eq("rst_walk_resp_valid", 32'(walk_resp_valid_o), 32'd0);
    chk_eq("rst_paddr", walk_paddr_o, 32'h0);
    chk_eq("rst_mem_addr", mem_addr_o, 32'h0);
    rst_n = 1'b1;
    #1 chk_eq("rst_req_ready", 32'(walk_req_ready_o), 32'd1);

    run_walk(32'h0000_0123, mk(32'h1000_0123, 4'hF, 1'b0, 1'b0, 2, 32'h400, 32'h800), 6, 0, 0);
    run_walk(32'h0000_1ABC, mk(32'h1100_0ABC, 4'hF, 1'b0, 1'b0, 2, 32'h400, 32'h804), 6, 0, 0);
    run_walk(32'h0000_2010, mk(32'h1200_0010, 4'h7, 1'b0, 1'b0, 2, 32'h400, 32'h808), 6, 0, 0);
    run_walk(32'h0000_3000, mk(32'h0, 4'h0, 1'b0, 1'b1, 2, 32'h400, 32'h80C), 6, 0, 0);
    run_walk(32'h0080_0000, mk(32'h0, 4'h0, 1'b0, 1'b1, 1, 32'h408, 32'h0), 4, 0, 0);
    run_walk(32'h0040_0000, mk(32'h0, 4'h7, 1'b1, 1'b1, 1, 32'h404, 32'h0), 4, 0, 0);
    mem[32'h404] = 32'h1200_0007;
    run_walk(32'h0040_0000, mk(32'h1200_0000, 4'h7, 1'b1, 1'b0, 1, 32'h404, 32'h0), 4, 0, 0);
    run_walk(32'h0047_5ABC, mk(32'h1207_5ABC, 4'h7, 1'b1, 1'b0, 1, 32'h404, 32'h0), 4, 0, 0);
    // pointer at level 0 must fault and report that PTE's low bits
    mem[32'h80C] = 32'h0000_0C01;
    run_walk(32'h0000_3000, mk(32'h0, 4'h1, 1'b0, 1'b1, 2, 32'h400, 32'h80C), 6, 0, 0);
    mem[32'h80C] = 32'h0000_0000;

    // request stalled 3 cycles, result held 5 cycles
    run_walk(32'h0000_1ABC, mk(32'h1100_0ABC, 4'hF, 1'b0, 1'b0, 2, 32'h400, 32'h804), 0, 3, 5);

    // reset during L0_WAIT
    @(negedge clk);
    walk_req_valid_i = 1'b1;
    walk_vaddr_i     = 32'h0000_0123;
    @(posedge clk);
    #1 walk_req_valid_i = 1'b0;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (mem_resp_ready_o && rd_q.size() == 2) break;
    end
    chk_eq("reached_l0_wait", 32'(mem_resp_ready_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("abort_mem_req_valid", 32'(mem_req_valid_o), 32'd0);
    chk_eq("abort_mem_resp_ready", 32'(mem_resp_ready_o), 32'd0);
    chk_eq("abort_walk_resp_valid", 32'(walk_resp_valid_o), 32'd0);
    rd_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk_eq("abort_req_ready", 32'(walk_req_ready_o), 32'd1);

    run_walk(32'h0000_2010, mk(32'h1200_0010, 4'h7, 1'b0, 1'b0, 2, 32'h400, 32'h808), 6, 0, 0);
    chk_eq("sb_drained", sb.size(), 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
